mips_alu: RTL and testbench
===========================

// Module: mips_alu
// PURPOSE
// - Registered 32-bit MIPS-subset ALU: decodes a full 32-bit instruction word and executes it on two operand registers.
// - Sits in the execute stage. Produces the result word (ALU value, slt bit, branch difference or load/store address).
// - Produces 3 status flags for the branch and compare logic downstream.
// PARAMETERS
// - none (datapath fixed at 32 bits; encodings are constants in the shared package)
// PORTS
// - clk          in   1   single clock, rising edge
// - rst_n        in   1   asynchronous, active-low reset
// - instruction  in   32  MIPS instruction word
// - regA         in   32  operand register at address 0
// - regB         in   32  operand register at address 1
// - result       out  32  registered ALU result
// - flags        out  3   registered {zero, negative, overflow} = flags[2:0]
// BEHAVIOUR
// - One clock, rst_n asynchronous active-low. While rst_n=0: result=0, flags=3'b000.
// - Latency: combinational compute from the inputs, captured at posedge clk. Outputs reflect the inputs of the previous edge. No handshake.
// - Fields: op=[31:26], rs=[25:21], rt=[20:16], shamt=[10:6], funct=[5:0], imm=[15:0].
// - Operand select: register field bit0=0 -> regA, bit0=1 -> regB (upper 4 bits ignored). S=src(rs), T=src(rt).
// - SE=sign-extended imm; ZE=zero-extended imm.
// - R-type (op=0), selected by funct:
//   - 20 add  S+T, overflow flag on signed overflow
//   - 21 addu S+T
//   - 22 sub  S-T, overflow flag on signed overflow
//   - 23 subu S-T
//   - 24 and; 25 or; 26 xor; 27 nor (~(S|T))
//   - 2A slt  signed S<T; 2B sltu unsigned S<T
//   - 00 sll  T<<shamt; 02 srl T>>shamt (logical); 03 sra T>>>shamt (arithmetic)
//   - 04 sllv T<<S[4:0]; 06 srlv T>>S[4:0] (logical); 07 srav T>>>S[4:0] (arithmetic)
// - I-type, selected by op:
//   - 08 addi  S+SE, overflow flag on signed overflow
//   - 09 addiu S+SE
//   - 0C andi S&ZE; 0D ori S|ZE; 0E xori S^ZE
//   - 0A slti  signed S<SE; 0B sltiu unsigned S<SE
//   - 04 beq / 05 bne: result=S-T, zero flag = (S==T)
//   - 23 lw / 2B sw: result=S+SE (address), no flags
// - slt* results: result={31'b0,lt} and negative flag=lt.
// - Overflowing add/sub/addi: result holds the wrapped 32-bit value, overflow=1.
// - Shift amounts 0..31; amount 0 passes T through unchanged.
// - Flags not named for an opcode are 0.
// - Unsupported op/funct: result=0, flags=000 (no trap).
// - Reset asserted mid-stream clears the outputs immediately. The first edge after release captures the current inputs.
// STRUCTURE
// - Shared package mips_alu_pkg: opcode and funct localparams, flag bit indices (FLG_ZERO=2, FLG_NEG=1, FLG_OVF=0).
// - Single sub-module mips_alu_comb: purely combinational decode+execute. Top adds only operand select and the output register.
// TESTING (check values one cycle after applying inputs)
// - add ovf: instr=00200020, regA=7FFFFFFF, regB=00000006 -> result=80000005, flags=001.
// - sub: instr=00010022, regA=4, regB=3 -> result=00000001, flags=000.
//   sub ovf: regA=7FFFFFFF, regB=FFFFFFFF -> result=80000000, flags=001.
// - sltu: instr=0001002B, regA=0, regB=FFFFFFFF -> result=1, flags=010.
//   slti: instr=28010001, regA=0 -> result=1, flags=010.
// - shifts, regB=0x80000000:
//   - sll instr=00010280, regB=1 -> 00000400.
//   - sra instr=00010083 -> E0000000.
//   - srlv instr=00010006, regA=4, regB=100 -> 00000010.
// - beq: instr=10010001, regA=regB=1 -> result=0, flags=100; regA=0 -> result=FFFFFFFF, flags=000.
//   lw: instr=8C01700F, regA=100 -> result=0000710F.
// - reset: drive rst_n=0 between edges while outputs are nonzero -> result=0, flags=000 immediately, without a clock edge.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// Shared encodings for the MIPS-subset ALU: opcodes, R-type functs,
// flag bit positions and signed-overflow helpers.
package mips_alu_pkg;

  // Primary opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instruction[5:0])
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  // Flag bit positions within flags[2:0]
  localparam int unsigned FLG_ZERO = 2;
  localparam int unsigned FLG_NEG  = 1;
  localparam int unsigned FLG_OVF  = 0;

  // Signed overflow of a+b=s: operands agree in sign, sum does not
  function automatic logic add_ovf(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] s);
    return (a[31] == b[31]) && (s[31] != a[31]);
  endfunction

  // Signed overflow of a-b=d: operands differ in sign, result differs from a
  function automatic logic sub_ovf(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] d);
    return (a[31] != b[31]) && (d[31] != a[31]);
  endfunction

endpackage

// File: rtl/mips_alu_if.sv
// Bundle between the operand/register stage and the decode+execute core:
// instruction and selected operands in, unregistered result and flags out.
interface mips_alu_if;
  logic [31:0] instruction;
  logic [31:0] opnd_a;
  logic [31:0] opnd_b;
  logic [31:0] result;
  logic [2:0]  flags;

  modport master (output instruction, opnd_a, opnd_b, input  result, flags);
  modport slave  (input  instruction, opnd_a, opnd_b, output result, flags);
endinterface

// File: rtl/mips_alu_comb.sv
// Purely combinational decode and execute. opnd_a is S (from rs),
// opnd_b is T (from rt); operand selection happens in the caller.
module mips_alu_comb
  import mips_alu_pkg::*;
(
  mips_alu_if.slave bus
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] s, t, se, ze;
  logic [31:0] sum_t, diff_t, sum_se;
  logic        unused_fields;

  assign op     = bus.instruction[31:26];
  assign funct  = bus.instruction[5:0];
  assign shamt  = bus.instruction[10:6];
  assign imm    = bus.instruction[15:0];
  assign s      = bus.opnd_a;
  assign t      = bus.opnd_b;
  assign se     = {{16{imm[15]}}, imm};
  assign ze     = {16'h0000, imm};
  assign sum_t  = s + t;
  assign diff_t = s - t;
  assign sum_se = s + se;

  // Register-field bits only matter for operand select upstream
  assign unused_fields = ^bus.instruction[25:16];

  // Decode op/funct into result and flags; unsupported encodings yield zeros
  always_comb begin
    bus.result = '0;
    bus.flags  = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADD: begin
            bus.result         = sum_t;
            bus.flags[FLG_OVF] = add_ovf(s, t, sum_t);
          end
          F_ADDU: bus.result = sum_t;
          F_SUB: begin
            bus.result         = diff_t;
            bus.flags[FLG_OVF] = sub_ovf(s, t, diff_t);
          end
          F_SUBU: bus.result = diff_t;
          F_AND:  bus.result = s & t;
          F_OR:   bus.result = s | t;
          F_XOR:  bus.result = s ^ t;
          F_NOR:  bus.result = ~(s | t);
          F_SLT: begin
            bus.result[0]      = $signed(s) < $signed(t);
            bus.flags[FLG_NEG] = $signed(s) < $signed(t);
          end
          F_SLTU: begin
            bus.result[0]      = s < t;
            bus.flags[FLG_NEG] = s < t;
          end
          F_SLL:  bus.result = t << shamt;
          F_SRL:  bus.result = t >> shamt;
          F_SRA:  bus.result = 32'($signed(t) >>> shamt);
          F_SLLV: bus.result = t << s[4:0];
          F_SRLV: bus.result = t >> s[4:0];
          F_SRAV: bus.result = 32'($signed(t) >>> s[4:0]);
          default: ;
        endcase
      end
      OP_ADDI: begin
        bus.result         = sum_se;
        bus.flags[FLG_OVF] = add_ovf(s, se, sum_se);
      end
      OP_ADDIU: bus.result = sum_se;
      OP_ANDI:  bus.result = s & ze;
      OP_ORI:   bus.result = s | ze;
      OP_XORI:  bus.result = s ^ ze;
      OP_SLTI: begin
        bus.result[0]      = $signed(s) < $signed(se);
        bus.flags[FLG_NEG] = $signed(s) < $signed(se);
      end
      OP_SLTIU: begin
        bus.result[0]      = s < se;
        bus.flags[FLG_NEG] = s < se;
      end
      OP_BEQ, OP_BNE: begin
        bus.result          = diff_t;
        bus.flags[FLG_ZERO] = (s == t);
      end
      OP_LW, OP_SW: bus.result = sum_se;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_alu.sv
// Registered MIPS-subset ALU: selects S/T from regA/regB by the low bit of
// rs/rt, executes through mips_alu_comb, and registers result and flags.
module mips_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic [31:0] regA,
  input  logic [31:0] regB,
  output logic [31:0] result,
  output logic [2:0]  flags
);

  mips_alu_if u_bus ();

  logic [31:0] result_d, result_q;
  logic [2:0]  flags_d, flags_q;

  assign u_bus.instruction = instruction;
  assign u_bus.opnd_a      = instruction[21] ? regB : regA;
  assign u_bus.opnd_b      = instruction[16] ? regB : regA;
  assign result_d          = u_bus.result;
  assign flags_d           = u_bus.flags;

  mips_alu_comb u_comb (
    .bus (u_bus)
  );

  // Output register, cleared asynchronously while reset is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_mips_alu.sv
// Scoreboard bench for mips_alu: the driver pushes expected outputs when it
// applies an instruction, the monitor pops one per clock and compares.
module tb_mips_alu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mips_alu_if tb_bus ();

  mips_alu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (tb_bus.instruction),
    .regA        (tb_bus.opnd_a),
    .regB        (tb_bus.opnd_b),
    .result      (tb_bus.result),
    .flags       (tb_bus.flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] instr;
    logic [31:0] res;
    logic [2:0]  fl;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural reference: wide signed arithmetic for overflow detection
  function automatic void model(input logic [31:0] ins, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] r,
                                output logic [2:0] f);
    logic [31:0] s, t, se, ze;
    logic [5:0]  op, fn;
    logic [4:0]  sh;
    longint sv, tv, sev, wide;
    longint maxs, mins;
    maxs = 64'sh7FFFFFFF;
    mins = -64'sh80000000;
    s  = ins[21] ? b : a;
    t  = ins[16] ? b : a;
    op = ins[31:26];
    fn = ins[5:0];
    sh = ins[10:6];
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0, ins[15:0]};
    sv = $signed(s);
    tv = $signed(t);
    sev = $signed(se);
    r = 32'h0;
    f = 3'b000;
    if (op == 6'h00) begin
      case (fn)
        6'h20: begin wide = sv + tv; r = wide[31:0]; f[0] = (wide > maxs) || (wide < mins); end
        6'h21: r = s + t;
        6'h22: begin wide = sv - tv; r = wide[31:0]; f[0] = (wide > maxs) || (wide < mins); end
        6'h23: r = s - t;
        6'h24: r = s & t;
        6'h25: r = s | t;
        6'h26: r = s ^ t;
        6'h27: r = ~(s | t);
        6'h2A: begin r = (sv < tv) ? 32'd1 : 32'd0; f[1] = (sv < tv); end
        6'h2B: begin r = (s < t) ? 32'd1 : 32'd0; f[1] = (s < t); end
        6'h00: r = t << sh;
        6'h02: r = t >> sh;
        6'h03: r = 32'(tv >>> sh);
        6'h04: r = t << s[4:0];
        6'h06: r = t >> s[4:0];
        6'h07: r = 32'(tv >>> s[4:0]);
        default: ;
      endcase
    end else begin
      case (op)
        6'h08: begin wide = sv + sev; r = wide[31:0]; f[0] = (wide > maxs) || (wide < mins); end
        6'h09: r = s + se;
        6'h0C: r = s & ze;
        6'h0D: r = s | ze;
        6'h0E: r = s ^ ze;
        6'h0A: begin r = (sv < sev) ? 32'd1 : 32'd0; f[1] = (sv < sev); end
        6'h0B: begin r = (s < se) ? 32'd1 : 32'd0; f[1] = (s < se); end
        6'h04, 6'h05: begin r = s - t; f[2] = (s == t); end
        6'h23, 6'h2B: r = s + se;
        default: ;
      endcase
    end
  endfunction

  // Drive one instruction at the falling edge and log its expected response
  task automatic issue(input string tag, input logic [31:0] ins,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic use_const, input logic [31:0] cr,
                       input logic [2:0] cf);
    exp_t e;
    @(negedge clk);
    tb_bus.instruction = ins;
    tb_bus.opnd_a      = a;
    tb_bus.opnd_b      = b;
    e.tag = tag;
    e.instr = ins;
    if (use_const) begin
      e.res = cr;
      e.fl  = cf;
    end else begin
      model(ins, a, b, e.res, e.fl);
    end
    exp_q.push_back(e);
  endtask

  task automatic direct(input string tag, input logic [31:0] ins,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] cr, input logic [2:0] cf);
    issue(tag, ins, a, b, 1'b1, cr, cf);
  endtask

  // Monitor: outputs reflect the previous edge's inputs
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (tb_bus.result !== e.res || tb_bus.flags !== e.fl) begin
        n_bad++;
        $display("FAIL %s instr=%h: got result=%h flags=%b, want result=%h flags=%b",
                 e.tag, e.instr, tb_bus.result, tb_bus.flags, e.res, e.fl);
      end
    end
  end

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] pick_instr();
    logic [5:0] rfn[16];
    logic [5:0] iop[12];
    logic [31:0] w;
    rfn = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    iop = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B,
            6'h04, 6'h05, 6'h23, 6'h2B, 6'h08};
    w = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: begin w[31:26] = 6'h00; w[5:0] = rfn[$urandom_range(0, 15)]; end
      4, 5, 6, 7: w[31:26] = iop[$urandom_range(0, 11)];
      default: ;
    endcase
    return w;
  endfunction

  task automatic check_now(input string tag, input logic [31:0] wr, input logic [2:0] wf);
    n_cmp++;
    if (tb_bus.result !== wr || tb_bus.flags !== wf) begin
      n_bad++;
      $display("FAIL %s: got result=%h flags=%b, want result=%h flags=%b",
               tag, tb_bus.result, tb_bus.flags, wr, wf);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    logic [31:0] a, b;
    tb_bus.instruction = '0;
    tb_bus.opnd_a = '0;
    tb_bus.opnd_b = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_now("reset_state", 32'h0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    direct("add_ovf",  32'h0020_0020, 32'h7FFF_FFFF, 32'h0000_0006, 32'h8000_0005, 3'b001);
    direct("sub",      32'h0001_0022, 32'h4,         32'h3,         32'h0000_0001, 3'b000);
    direct("sub_ovf",  32'h0001_0022, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 3'b001);
    direct("sltu",     32'h0001_002B, 32'h0,         32'hFFFF_FFFF, 32'h0000_0001, 3'b010);
    direct("slti",     32'h2801_0001, 32'h0,         32'h0,         32'h0000_0001, 3'b010);
    direct("sll",      32'h0001_0280, 32'h0,         32'h1,         32'h0000_0400, 3'b000);
    direct("sra",      32'h0001_0083, 32'h0,         32'h8000_0000, 32'hE000_0000, 3'b000);
    direct("srl",      32'h0001_0082, 32'h0,         32'h8000_0000, 32'h2000_0000, 3'b000);
    direct("srlv",     32'h0001_0006, 32'h4,         32'h100,       32'h0000_0010, 3'b000);
    direct("sll_zero", 32'h0001_0000, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b000);
    direct("sra_31",   32'h0001_07C3, 32'h0,         32'h8000_0000, 32'hFFFF_FFFF, 3'b000);
    direct("beq_eq",   32'h1001_0001, 32'h1,         32'h1,         32'h0000_0000, 3'b100);
    direct("beq_ne",   32'h1001_0001, 32'h0,         32'h1,         32'hFFFF_FFFF, 3'b000);
    direct("lw",       32'h8C01_700F, 32'h100,       32'h0,         32'h0000_710F, 3'b000);
    direct("bad_fn",   32'h0001_0008, 32'h5,         32'h6,         32'h0000_0000, 3'b000);
    direct("bad_op",   32'hFC01_0000, 32'h5,         32'h6,         32'h0000_0000, 3'b000);
    direct("addi_ovf", 32'h2000_0001, 32'h7FFF_FFFF, 32'h0,         32'h8000_0000, 3'b001);

    for (int i = 0; i < 400; i++) begin
      a = pick_val();
      b = ($urandom_range(0, 7) == 0) ? a : pick_val();
      issue("random", pick_instr(), a, b, 1'b0, '0, '0);
    end
    drain();

    // Load nonzero outputs, then assert reset between edges
    direct("pre_reset", 32'h0020_0020, 32'h7FFF_FFFF, 32'h0000_0006, 32'h8000_0005, 3'b001);
    drain();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_now("async_reset", 32'h0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    direct("post_reset", 32'h0001_0024, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 3'b000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
